// File: rtl/shift_pkg.sv
// Shared op encodings and small decode helpers for the barrel shifter pipeline.
package shift_pkg;

    localparam int SHIFT_OP_W = 3;

    typedef enum logic [SHIFT_OP_W-1:0] {
        SHIFT_ROL = 3'b000,
        SHIFT_SLL = 3'b001,
        SHIFT_ROR = 3'b010,
        SHIFT_SRL = 3'b011,
        SHIFT_SRA = 3'b100
    } shift_op_e;

    function automatic logic op_is_left(input logic [SHIFT_OP_W-1:0] op);
        return (op == SHIFT_ROL) || (op == SHIFT_SLL);
    endfunction

    function automatic logic op_is_legal(input logic [SHIFT_OP_W-1:0] op);
        return op <= SHIFT_SRA;
    endfunction

endpackage

// File: rtl/shift_barrel_pipe_if.sv
// Operand/result handshake bundle for shift_barrel_pipe; out_zero/out_cout exist only with SHIFT_FLAGS_EN.
interface shift_barrel_pipe_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic [CNT_W-1:0]      in_cnt;
    logic [SHIFT_OP_W-1:0] in_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
`ifdef SHIFT_FLAGS_EN
    logic                  out_zero;
    logic                  out_cout;
`endif

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data
`ifdef SHIFT_FLAGS_EN
        , input out_zero, out_cout
`endif
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data
`ifdef SHIFT_FLAGS_EN
        , output out_zero, out_cout
`endif
    );

endinterface

// File: rtl/shift_stage_mux.sv
// One combinational rank: shift/rotate by 2^AMT when i_en, pass-through otherwise or for reserved ops.
// i_sign is the fill bit used by SRA.
module shift_stage_mux
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT   = 0
) (
    input  logic [WIDTH-1:0]      i_data,
    input  logic [SHIFT_OP_W-1:0] i_op,
    input  logic                  i_en,
    input  logic                  i_sign,
    output logic [WIDTH-1:0]      o_data
);
    localparam int SH = 1 << AMT;

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                SHIFT_ROL: o_data = {i_data[WIDTH-SH-1:0], i_data[WIDTH-1:WIDTH-SH]};
                SHIFT_SLL: o_data = {i_data[WIDTH-SH-1:0], {SH{1'b0}}};
                SHIFT_ROR: o_data = {i_data[SH-1:0], i_data[WIDTH-1:SH]};
                SHIFT_SRL: o_data = {{SH{1'b0}}, i_data[WIDTH-1:SH]};
                SHIFT_SRA: o_data = {{SH{i_sign}}, i_data[WIDTH-1:SH]};
                default:   o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_barrel_pipe.sv
// Pipelined barrel shifter, one log2 rank per register stage; SHIFT_FLAGS_EN adds out_zero/out_cout.
// Latency CNT_W-1 cycles after accept; every rank holds while out_valid && !out_ready (in_ready = 0).
module shift_barrel_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    shift_barrel_pipe_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                  w_in_vld  [CNT_W];
    logic [WIDTH-1:0]      w_in_data [CNT_W];
    logic [CNT_W-1:0]      w_in_cnt  [CNT_W];
    logic [SHIFT_OP_W-1:0] w_in_op   [CNT_W];
    logic [WIDTH-1:0]      w_shift   [CNT_W];
    logic                  w_q_vld   [CNT_W];
    logic [WIDTH-1:0]      w_q_data  [CNT_W];
    logic [CNT_W-1:0]      w_q_cnt   [CNT_W];
    logic [SHIFT_OP_W-1:0] w_q_op    [CNT_W];
    logic [CNT_W-1:0]      w_unused_par;
    logic                  w_adv;
`ifdef SHIFT_FLAGS_EN
    logic                  w_in_cout [CNT_W];
    logic                  w_q_cout  [CNT_W];
`endif

    assign w_adv        = !w_q_vld[CNT_W-1] || bus.out_ready;
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < CNT_W; k++) begin : g_rank
        if (k == 0) begin : g_head
            assign w_in_vld[k]  = bus.in_valid;
            assign w_in_data[k] = bus.in_data;
            assign w_in_cnt[k]  = bus.in_cnt;
            assign w_in_op[k]   = bus.in_op;
`ifdef SHIFT_FLAGS_EN
            assign w_in_cout[k] = 1'b0;
`endif
        end else begin : g_tail
            assign w_in_vld[k]  = w_q_vld[k-1];
            assign w_in_data[k] = w_q_data[k-1];
            assign w_in_cnt[k]  = w_q_cnt[k-1];
            assign w_in_op[k]   = w_q_op[k-1];
`ifdef SHIFT_FLAGS_EN
            assign w_in_cout[k] = w_q_cout[k-1];
`endif
        end

        // For SRA the current MSB always equals the original sign bit, so it serves as the fill.
        shift_stage_mux #(.WIDTH(WIDTH), .AMT(k)) u_mux (
            .i_data (w_in_data[k]),
            .i_op   (w_in_op[k]),
            .i_en   (w_in_cnt[k][k]),
            .i_sign (w_in_data[k][WIDTH-1]),
            .o_data (w_shift[k])
        );

        logic                  r_vld;
        logic [WIDTH-1:0]      r_data;
        logic [CNT_W-1:0]      r_cnt;
        logic [SHIFT_OP_W-1:0] r_op;
`ifdef SHIFT_FLAGS_EN
        // The last active rank decides which bit left the word last; idle ranks carry it forward.
        logic r_cout;
        logic w_cout_nxt;
        assign w_cout_nxt = (w_in_cnt[k][k] && op_is_legal(w_in_op[k]))
                          ? (op_is_left(w_in_op[k]) ? w_in_data[k][WIDTH-(1<<k)]
                                                    : w_in_data[k][(1<<k)-1])
                          : w_in_cout[k];
        assign w_q_cout[k] = r_cout;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_cnt  <= '0;
                r_op   <= '0;
`ifdef SHIFT_FLAGS_EN
                r_cout <= 1'b0;
`endif
            end else if (w_adv) begin
                r_vld  <= w_in_vld[k];
                r_data <= w_shift[k];
                r_cnt  <= w_in_cnt[k];
                r_op   <= w_in_op[k];
`ifdef SHIFT_FLAGS_EN
                r_cout <= w_cout_nxt;
`endif
            end
        end

        assign w_q_vld[k]      = r_vld;
        assign w_q_data[k]     = r_data;
        assign w_q_cnt[k]      = r_cnt;
        assign w_q_op[k]       = r_op;
        assign w_unused_par[k] = ^{w_in_cnt[k], w_q_cnt[k], w_q_op[k]};
    end

    assign bus.out_valid = w_q_vld[CNT_W-1];
    assign bus.out_data  = w_q_data[CNT_W-1];

`ifdef SHIFT_FLAGS_EN
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (w_adv) begin
            r_zero <= (w_shift[CNT_W-1] == '0);
        end
    end

    assign bus.out_zero = r_zero;
    assign bus.out_cout = w_q_cout[CNT_W-1];
`endif

endmodule

// File: tb/tb_shift_barrel_pipe.sv
// Directed and randomized checks of shift_barrel_pipe against a word-level reference model and scoreboard.
module tb_shift_barrel_pipe;
    localparam int W     = 16;
    localparam int CNT_W = $clog2(W);

    typedef struct {
        logic [W-1:0] d;
        logic         z;
        logic         c;
        int           acc;
        int           stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rdy_mode;
    int   neg_idx = 0;
    int   stalls  = 0;
    logic prev_rst   = 1'b0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         drv_use;
    logic [W-1:0] drv_exp;
    exp_t q[$];

    shift_barrel_pipe_if #(.WIDTH(W)) bus ();

    shift_barrel_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input int c, input int op);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        dd = {d, d};
        r  = d;
        case (op)
            0: begin dd = dd << c; r = dd[2*W-1:W]; end
            1: r = d << c;
            2: begin dd = dd >> c; r = dd[W-1:0]; end
            3: r = d >> c;
            4: for (int i = 0; i < W; i++) r[i] = (i + c < W) ? d[i+c] : d[W-1];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic model_cout(input logic [W-1:0] d, input int c, input int op);
        if (c == 0 || op > 4) return 1'b0;
        if (op == 0 || op == 1) return d[W-c];
        return d[c-1];
    endfunction

    task automatic mon_step();
        exp_t e;
        @(negedge clk);
        neg_idx++;
        chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (prev_rst) begin
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_out_data", bus.out_data, '0);
`ifdef SHIFT_FLAGS_EN
            chk("rst_out_zero", bus.out_zero, 1'b0);
            chk("rst_out_cout", bus.out_cout, 1'b0);
`endif
        end
        if (prev_stall) begin
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_data", bus.out_data, prev_data);
        end
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                chk("orphan_result", q.size() == 0, 1'b0);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("data", bus.out_data, e.d);
                    chk("latency", (neg_idx - 1) - e.acc, CNT_W - 1 + stalls - e.stl);
`ifdef SHIFT_FLAGS_EN
                    chk("zero", bus.out_zero, e.z);
                    chk("cout", bus.out_cout, e.c);
`endif
                end
            end
            if (bus.out_valid && !bus.out_ready) stalls++;
            if (bus.in_valid && bus.in_ready) begin
                e.d   = drv_use ? drv_exp
                              : model_data(bus.in_data, int'(bus.in_cnt), int'(bus.in_op));
                e.z   = (e.d == '0);
                e.c   = model_cout(bus.in_data, int'(bus.in_cnt), int'(bus.in_op));
                e.acc = neg_idx;
                e.stl = stalls;
                q.push_back(e);
            end
        end
        prev_rst   = rst;
        prev_stall = !rst && bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [CNT_W-1:0] c, input logic [2:0] op,
                        input logic use_exp, input logic [W-1:0] exp);
        logic acc;
        acc          = 1'b0;
        bus.in_data  = d;
        bus.in_cnt   = c;
        bus.in_op    = op;
        drv_use      = use_exp;
        drv_exp      = exp;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst           = 1'b1;
        rdy_mode      = 0;
        drv_use       = 1'b0;
        drv_exp       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_cnt    = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;

        fork
            forever mon_step();
            forever begin
                @(posedge clk);
                #1;
                case (rdy_mode)
                    1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                    2:       bus.out_ready = 1'b0;
                    default: bus.out_ready = 1'b1;
                endcase
            end
            begin
                #900000;
                $display("FAIL watchdog: sim time %0t reached, required finish before it", $time);
                $fatal(1);
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        send(16'h8001, 4'd8,  3'b100, 1'b1, 16'hFF80);
        send(16'h8001, 4'd8,  3'b011, 1'b1, 16'h0080);
        send(16'h8001, 4'd8,  3'b010, 1'b1, 16'h0180);
        send(16'h1234, 4'd4,  3'b000, 1'b1, 16'h2341);
        send(16'h1234, 4'd4,  3'b001, 1'b1, 16'h2340);
        send(16'h8000, 4'd15, 3'b100, 1'b1, 16'hFFFF);
        send(16'h8001, 4'd15, 3'b001, 1'b1, 16'h8000);
        send(16'h8001, 4'd15, 3'b011, 1'b1, 16'h0001);
        for (int op = 0; op < 5; op++) send(16'hA5C3, 4'd0, op[2:0], 1'b1, 16'hA5C3);
        send(16'h5A3C, 4'd5,  3'b111, 1'b1, 16'h5A3C);
        send(16'h5A3C, 4'd9,  3'b101, 1'b1, 16'h5A3C);
        send(16'h8000, 4'd1,  3'b001, 1'b1, 16'h0000);
        send(16'h0003, 4'd1,  3'b011, 1'b1, 16'h0001);
        drain();

        fork
            for (int i = 0; i < 8; i++)
                send(16'h1111 * i[15:0] + 16'h0F0F, i[3:0] + 4'd1, i[2:0] % 3'd5, 1'b0, '0);
            begin
                repeat (5) @(posedge clk);
                rdy_mode = 2;
                repeat (3) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) send(16'hC3A5 ^ i[15:0], 4'd3, 3'b000, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(16'h00FF, 4'd8, 3'b001, 1'b1, 16'hFF00);
        drain();

        rdy_mode = 1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), CNT_W'($urandom_range(0, W - 1)), 3'($urandom_range(0, 7)), 1'b0, '0);
        end
        drain();
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
